// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - round-robin PCI bus arbiter with hidden arbitration and grant timeout
//
// Purpose:
//   Drives the active-low grant line of each PCI bus master. Requests are
//   served in round-robin order starting after the last master that actually
//   ran a transaction. While a transaction is in progress the next grant is
//   placed in advance (hidden arbitration). A grant that is never used is
//   revoked after TIMEOUT cycles.
//
// Ports:
//   clk          bus clock, all state changes on posedge
//   areset_n     asynchronous active-low reset
//   req          active-low request, one bit per master
//   Frame, IRDY  shared active-low PCI bus signals (inputs only)
//   gnt          active-low grant, registered, at most one bit low
//   owner        index of the current or pending grantee, registered
//   owner_valid  high while some gnt bit is low
//   bus_idle     registered Frame & IRDY

module pci_arbiter #(
  parameter int NUM_DEV = 3,
  parameter int TIMEOUT = 16,
  parameter int IW      = $clog2(NUM_DEV)
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic [NUM_DEV-1:0] req,
  input  logic               Frame,
  input  logic               IRDY,
  output logic [NUM_DEV-1:0] gnt,
  output logic [IW-1:0]      owner,
  output logic               owner_valid,
  output logic               bus_idle
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_DEV-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               owner_valid_q, owner_valid_d;
  logic               bus_idle_q, bus_idle_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               sample_idle;
  logic               rr_found;
  logic [IW-1:0]      rr_idx;
  logic [NUM_DEV-1:0] rr_gnt;

  assign sample_idle = Frame & IRDY;

  // Round-robin pick relative to ptr_q. Scanning from the farthest position
  // back to the nearest lets the nearest requester overwrite the others, so
  // ptr_q itself (offset NUM_DEV) has the lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = NUM_DEV; i >= 1; i--) begin : scan
      logic [IW-1:0] cand;
      cand = IW'((int'(ptr_q) + i) % NUM_DEV);
      if (!req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    rr_gnt = ~(NUM_DEV'(1) << rr_idx);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '1;
        cnt_d = '0;
        // Only grant on a sampled idle bus; this also makes the arbiter
        // wait out a transaction that was in flight across a reset.
        if (rr_found && sample_idle) begin
          gnt_d   = rr_gnt;
          owner_d = rr_idx;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // Frame has priority over both withdrawal and timeout.
        if (!Frame) begin
          state_d = ST_BUSY;
          ptr_d   = owner_q;
        end else if (req[owner_q]) begin
          gnt_d   = '1;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Advance the pointer so the silent master goes to the back.
          gnt_d   = '1;
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_BUSY: begin
        // ptr_q is the running master here, so it only keeps the grant
        // when nobody else asks. Re-evaluated every cycle.
        if (rr_found) begin
          gnt_d   = rr_gnt;
          owner_d = rr_idx;
        end else begin
          gnt_d = '1;
        end
        if (sample_idle) begin
          cnt_d   = '0;
          state_d = rr_found ? ST_GRANT : ST_IDLE;
        end
      end

      default: begin
        gnt_d   = '1;
        state_d = ST_IDLE;
      end
    endcase

    owner_valid_d = ~&gnt_d;
    bus_idle_d    = sample_idle;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '1;
      owner_q       <= '0;
      ptr_q         <= IW'(NUM_DEV - 1);
      owner_valid_q <= 1'b0;
      bus_idle_q    <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      owner_valid_q <= owner_valid_d;
      bus_idle_q    <= bus_idle_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign bus_idle    = bus_idle_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb/tb_pci_arbiter.sv - self-checking bench for pci_arbiter
module tb_pci_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [2:0] req;
  logic       Frame;
  logic       IRDY;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       owner_valid;
  logic       bus_idle;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the grant (-1 = nobody), whether that holder
  // is waiting to start or running, rotation pointer and wait counter.
  int m_gnt;
  int m_ptr;
  int m_cnt;
  int m_owner;
  bit m_waiting;
  bit m_in_txn;
  bit m_bus_idle;

  always #5 clk = ~clk;

  pci_arbiter #(.NUM_DEV(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .req        (req),
    .Frame      (Frame),
    .IRDY       (IRDY),
    .gnt        (gnt),
    .owner      (owner),
    .owner_valid(owner_valid),
    .bus_idle   (bus_idle)
  );

  function automatic int rr_pick(logic [2:0] r, int p);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (p + i) % N;
      if (r[2'(j)] == 1'b0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt      = -1;
    m_ptr      = N - 1;
    m_cnt      = 0;
    m_owner    = 0;
    m_waiting  = 0;
    m_in_txn   = 0;
    m_bus_idle = 1;
  endtask

  task automatic model_edge(logic [2:0] r, logic f, logic i);
    bit idle_now;
    int w;
    idle_now = f & i;
    w = rr_pick(r, m_ptr);
    if (m_waiting) begin
      if (!f) begin
        m_waiting = 0;
        m_in_txn  = 1;
        m_ptr     = m_gnt;
      end else if (r[2'(m_gnt)]) begin
        m_waiting = 0;
        m_gnt     = -1;
      end else if (m_cnt == TO - 1) begin
        m_waiting = 0;
        m_ptr     = m_gnt;
        m_gnt     = -1;
      end else begin
        m_cnt++;
      end
    end else if (m_in_txn) begin
      m_gnt = w;
      if (idle_now) begin
        m_in_txn = 0;
        if (w >= 0) begin
          m_waiting = 1;
          m_cnt     = 0;
        end
      end
    end else begin
      m_cnt = 0;
      if (idle_now && w >= 0) begin
        m_gnt     = w;
        m_waiting = 1;
      end
    end
    if (m_gnt >= 0) m_owner = m_gnt;
    m_bus_idle = idle_now;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [2:0] e;
    e = (m_gnt >= 0) ? ~(3'b001 << m_gnt) : 3'b111;
    chk("gnt", 32'(gnt), 32'(e));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("owner_valid", 32'(owner_valid), 32'(m_gnt >= 0));
    chk("bus_idle", 32'(bus_idle), 32'(m_bus_idle));
    chk("one_grant", 32'($countones(~gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    logic [2:0] r;
    logic f, i;
    r = req;
    f = Frame;
    i = IRDY;
    @(posedge clk);
    model_edge(r, f, i);
    #1;
    check_model();
  endtask

  initial begin
    int low_cycles;
    int prev;
    int k;

    areset_n = 1'b0;
    req      = 3'b111;
    Frame    = 1'b1;
    IRDY     = 1'b1;
    model_reset();
    #12;
    chk("reset_gnt", 32'(gnt), 32'(3'b111));
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_valid", 32'(owner_valid), 32'd0);
    chk("reset_bus_idle", 32'(bus_idle), 32'd1);

    // Release with device 0 requesting: one-cycle grant.
    req = 3'b110;
    #1 areset_n = 1'b1;
    step();
    chk("first_gnt", 32'(gnt), 32'(3'b110));
    chk("first_owner", 32'(owner), 32'd0);
    chk("first_valid", 32'(owner_valid), 32'd1);

    // Withdrawal keeps the pointer: device 0 wins again over device 1.
    req = 3'b111;
    step();
    chk("withdraw_gnt", 32'(gnt), 32'(3'b111));
    req = 3'b100;
    step();
    chk("rewin_gnt", 32'(gnt), 32'(3'b110));

    // Device 0 transaction; device 2 requests: hidden hand-over.
    Frame = 1'b0;
    step();
    req = 3'b011;
    step();
    chk("hidden_gnt", 32'(gnt), 32'(3'b011));
    Frame = 1'b1;
    step();
    chk("hidden_after_idle", 32'(gnt), 32'(3'b011));
    Frame = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk("busy_no_timeout", 32'(gnt), 32'(3'b011));
    Frame = 1'b1;
    req   = 3'b111;
    step();
    chk("busy_end_gnt", 32'(gnt), 32'(3'b111));

    // Timeout: device 1 never drives Frame.
    req = 3'b101;
    step();
    chk("to_grant", 32'(gnt), 32'(3'b101));
    low_cycles = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (gnt[1] == 1'b0) low_cycles++;
      else break;
    end
    chk("to_low_cycles", 32'(low_cycles), 32'(TO));
    chk("to_revoked", 32'(gnt), 32'(3'b111));
    req = 3'b001;
    step();
    chk("to_next_dev2", 32'(gnt), 32'(3'b011));

    // All requesting, 3-cycle transactions: strict rotation.
    req  = 3'b000;
    prev = -1;
    for (int t = 0; t < 9; t++) begin
      k = int'(owner);
      chk("rr_granted", 32'(gnt[owner]), 32'd0);
      if (prev >= 0) chk("rr_order", 32'(k), 32'((prev + 1) % N));
      prev  = k;
      Frame = 1'b0;
      step();
      step();
      step();
      Frame = 1'b1;
      step();
    end
    req = 3'b111;
    step();

    // Reset in the middle of device 1's transaction.
    req = 3'b101;
    step();
    Frame = 1'b0;
    step();
    chk("pre_reset_gnt", 32'(gnt), 32'(3'b101));
    #3 areset_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_gnt", 32'(gnt), 32'(3'b111));
    chk("async_reset_valid", 32'(owner_valid), 32'd0);
    #2 areset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("wait_idle_gnt", 32'(gnt), 32'(3'b111));
    end
    Frame = 1'b1;
    step();
    chk("post_reset_gnt", 32'(gnt), 32'(3'b101));

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req   = 3'($urandom);
      Frame = ($urandom_range(0, 9) >= 3);
      IRDY  = ($urandom_range(0, 9) >= 2);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
